packet_build: RTL
=================

PACKET_BUILD -- requirements
Module: packet_build

Interface
REQ-001 Parameter: DEPTH, 2, number of assembled-packet entries in the output buffer; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset; asserting it (low) resets all state immediately, independent of clk.
REQ-004 Port: field_in  input  2  one 2-bit packet field; order is head, body, tail.
REQ-005 Port: field_valid  input  1  field_in holds a valid field this cycle.
REQ-006 Port: field_ready  output  1  block accepts field_in this cycle.
REQ-007 Port: drop  input  1  abort the partially assembled packet.
REQ-008 Port: payload  output  6  assembled packet: [5:4]=head, [3:2]=body, [1:0]=tail.
REQ-009 Port: pkt_valid  output  1  payload holds the oldest buffered packet.
REQ-010 Port: pkt_ready  input  1  downstream consumes payload this cycle.
REQ-011 Port: pkt_cnt  output  8  count of packets completed since reset.

Function
REQ-012 A field SHALL transfer on a rising edge only when field_valid and field_ready are both high.
REQ-013 An assembly FSM SHALL have states S_HEAD, S_BODY and S_TAIL; a field transfer SHALL move it S_HEAD->S_BODY->S_TAIL->S_HEAD.
REQ-014 Transfers SHALL store field_in in the head, body or tail slot for the current state, respectively.
REQ-015 A transfer in S_TAIL SHALL push {head, body, field_in} into the output buffer on the same edge.
REQ-016 field_ready SHALL equal !drop && !(state==S_TAIL && buffer full); it SHALL be 1 in S_HEAD and S_BODY when drop is low.
REQ-017 A push and a pop on the same edge with the buffer full SHALL NOT occur: field_ready stays low when full, even if pkt_ready is high.
REQ-018 drop high on an edge SHALL return the FSM to S_HEAD and discard stored head/body; no field transfers; buffer contents and pkt_cnt are unaffected.
REQ-019 drop in S_HEAD SHALL be a no-op apart from holding field_ready low.
REQ-020 The output buffer SHALL be a DEPTH-entry FIFO with wrapping read/write pointers and an occupancy count of width log2(DEPTH)+1.
REQ-021 pkt_valid SHALL equal buffer not empty; payload SHALL equal the entry at the read pointer, or 6'b0 when empty.
REQ-022 A pop SHALL occur on an edge where pkt_valid and pkt_ready are both high; pkt_ready while empty SHALL be ignored.
REQ-023 Simultaneous push and pop with the buffer not full SHALL leave occupancy unchanged and preserve order.
REQ-024 Latency: a tail accepted on edge N into an empty buffer SHALL give pkt_valid=1 with that payload after edge N.
REQ-025 pkt_cnt SHALL increment by 1 on each S_TAIL transfer and wrap 255->0.
REQ-026 Packets SHALL leave in acceptance order with no loss or duplication.

Reset
REQ-027 While rst is low: FSM=S_HEAD, head/body slots=0, pointers and occupancy=0, pkt_cnt=0.
REQ-028 While rst is low: pkt_valid=0, payload=6'b0 and field_ready=1 (when drop is low).
REQ-029 rst asserted mid-packet or with buffered packets SHALL discard all partial and buffered data; the first field after release is a head.

Verification
REQ-030 Fields 2'b11, 2'b01, 2'b10 back-to-back with pkt_ready=1 -> payload=6'b110110, pkt_valid=1 for one cycle, pkt_cnt=1.
REQ-031 pkt_ready=0 and three packets offered -> two buffered (DEPTH=2), field_ready=0 in S_TAIL of the third; pkt_ready=1 -> packets drain in order, then the third completes.
REQ-032 Head 2'b01, body 2'b10, then drop=1 -> FSM=S_HEAD; next fields 2'b00, 2'b11, 2'b01 -> payload=6'b001101, pkt_cnt increments by 1 only.
REQ-033 drop=1 and field_valid=1 on the same edge -> field_ready=0, no transfer, FSM=S_HEAD.
REQ-034 256 packets streamed -> pkt_cnt wraps to 0; no packet lost.
REQ-035 rst low asynchronously with one buffered packet and FSM=S_BODY -> pkt_valid=0, payload=0, pkt_cnt=0 before the next clk edge.

Source files
------------

// File: rtl/packet_build_if.sv
// Field-side and packet-side handshake bundle for packet_build.
// The slave modport is the builder; the master modport is whoever feeds and drains it.
interface packet_build_if;
  logic [1:0] field_in;
  logic       field_valid;
  logic       field_ready;
  logic       drop;
  logic [5:0] payload;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [7:0] pkt_cnt;

  modport slave (
    input  field_in, field_valid, drop, pkt_ready,
    output field_ready, payload, pkt_valid, pkt_cnt
  );

  modport master (
    output field_in, field_valid, drop, pkt_ready,
    input  field_ready, payload, pkt_valid, pkt_cnt
  );
endinterface

// File: rtl/packet_build.sv
// Assembles head/body/tail 2-bit fields into 6-bit packets and queues them
// in a DEPTH-entry FIFO toward a ready/valid consumer.
module packet_build #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  packet_build_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_HEAD, S_BODY, S_TAIL} state_t;

  state_t          state_q, state_d;
  logic [1:0]      head_q, body_q;
  logic [5:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     occ;
  logic [7:0]      cnt;
  logic            full, empty, xfer, push, pop;

  assign full  = (occ == FULL_OCC);
  assign empty = (occ == '0);

  // A full buffer stalls only the tail, so a push never coincides with a full-buffer pop.
  assign bus.field_ready = !bus.drop && !(state_q == S_TAIL && full);
  assign xfer            = bus.field_valid && bus.field_ready;
  assign push            = xfer && (state_q == S_TAIL);
  assign pop             = !empty && bus.pkt_ready;

  assign bus.pkt_valid = !empty;
  assign bus.payload   = empty ? 6'b0 : mem[rd_ptr];
  assign bus.pkt_cnt   = cnt;

  always_comb begin
    state_d = state_q;
    if (bus.drop) begin
      state_d = S_HEAD;
    end else if (xfer) begin
      case (state_q)
        S_HEAD:  state_d = S_BODY;
        S_BODY:  state_d = S_TAIL;
        default: state_d = S_HEAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HEAD;
      head_q  <= 2'b0;
      body_q  <= 2'b0;
    end else begin
      state_q <= state_d;
      if (bus.drop) begin
        head_q <= 2'b0;
        body_q <= 2'b0;
      end else if (xfer && state_q == S_HEAD) begin
        head_q <= bus.field_in;
      end else if (xfer && state_q == S_BODY) begin
        body_q <= bus.field_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      cnt    <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        cnt    <= cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: payload is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {head_q, body_q, bus.field_in};
  end

endmodule
